// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA sync controller: coordinate width,
// counter range limit and the parameter sets for the supported video modes.
package vga_timing_pkg;

    // Width of the h/v position counters and of the row/column coordinates.
    localparam int COORD_W    = 11;

    // Largest period an 11-bit counter can step through (0..2047).
    localparam int MAX_PERIOD = 2048;

    typedef logic [COORD_W-1:0] coord_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative sync polarity.
    localparam int   VGA640_H_PIXELS = 640;
    localparam int   VGA640_H_FP     = 16;
    localparam int   VGA640_H_PULSE  = 96;
    localparam int   VGA640_H_BP     = 48;
    localparam logic VGA640_H_POL    = 1'b0;
    localparam int   VGA640_V_PIXELS = 480;
    localparam int   VGA640_V_FP     = 10;
    localparam int   VGA640_V_PULSE  = 2;
    localparam int   VGA640_V_BP     = 33;
    localparam logic VGA640_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive sync polarity.
    localparam int   VGA800_H_PIXELS = 800;
    localparam int   VGA800_H_FP     = 40;
    localparam int   VGA800_H_PULSE  = 128;
    localparam int   VGA800_H_BP     = 88;
    localparam logic VGA800_H_POL    = 1'b1;
    localparam int   VGA800_V_PIXELS = 600;
    localparam int   VGA800_V_FP     = 1;
    localparam int   VGA800_V_PULSE  = 4;
    localparam int   VGA800_V_BP     = 23;
    localparam logic VGA800_V_POL    = 1'b1;

    // Total length of one axis (visible + porches + pulse).
    function automatic int axis_period(input int visible, input int fp,
                                       input int pulse, input int bp);
        return visible + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/vga_sync_controller_if.sv
// Output bundle of the sync controller: sync pins, display enable,
// pixel coordinates and the frame/line start strobes.
interface vga_sync_controller_if;

    logic                         h_sync;
    logic                         v_sync;
    logic                         disp_ena;
    vga_timing_pkg::coord_t       column;
    vga_timing_pkg::coord_t       row;
    logic                         frame_start;
    logic                         line_start;

    // Timing generator side.
    modport master (
        output h_sync,
        output v_sync,
        output disp_ena,
        output column,
        output row,
        output frame_start,
        output line_start
    );

    // Image generator / DAC side.
    modport slave (
        input  h_sync,
        input  v_sync,
        input  disp_ena,
        input  column,
        input  row,
        input  frame_start,
        input  line_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a position counter that steps
// 0..period-1 when advanced, plus the decode of the position it will hold
// after the current edge, so the parent can register outputs that line up
// exactly with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   VISIBLE = 640,
    parameter int   FP      = 16,
    parameter int   PULSE   = 96,
    parameter int   BP      = 48,
    parameter logic POL     = 1'b0
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   advance_i,
    output logic   wrap_o,
    output logic   next_visible_o,
    output logic   next_sync_o,
    output coord_t next_coord_o
);

    localparam int PERIOD = axis_period(VISIBLE, FP, PULSE, BP);

    // Last position of the axis; reset parks the counter here so the first
    // advance after reset lands on position 0.
    localparam coord_t LAST = COORD_W'(PERIOD - 1);

    // Decode bounds are one bit wider than the counter so a sync pulse that
    // ends exactly at a 2048 period does not alias to 0.
    localparam logic [COORD_W:0] VIS_END    = (COORD_W+1)'(VISIBLE);
    localparam logic [COORD_W:0] SYNC_START = (COORD_W+1)'(VISIBLE + FP);
    localparam logic [COORD_W:0] SYNC_END   = (COORD_W+1)'(VISIBLE + FP + PULSE);

    coord_t           cnt_q;
    coord_t           cnt_d;
    logic             wrap_s;
    logic [COORD_W:0] cnt_ext_s;
    logic             visible_s;
    logic             sync_active_s;

    // Next position: hold, step, or wrap from the last position to zero.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_s = 1'b0;
        if (advance_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_s = 1'b1;
            end else begin
                cnt_d  = cnt_q + 11'd1;
                wrap_s = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            wrap_s = 1'b0;
        end
    end

    // Position register; reset parks it at the last position of the axis.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decode of the upcoming position: visible window, sync window, coordinate.
    always_comb begin
        cnt_ext_s      = {1'b0, cnt_d};
        visible_s      = (cnt_ext_s < VIS_END);
        sync_active_s  = (cnt_ext_s >= SYNC_START) && (cnt_ext_s < SYNC_END);
        next_visible_o = visible_s;
        next_coord_o   = '0;
        next_sync_o    = ~POL;
        if (visible_s) begin
            next_coord_o = cnt_d;
        end else begin
            next_coord_o = '0;
        end
        if (sync_active_s) begin
            next_sync_o = POL;
        end else begin
            next_sync_o = ~POL;
        end
    end

    assign wrap_o = wrap_s;

endmodule

// File: rtl/vga_sync_controller.sv
// VGA timing controller. Free-runs over the frame raster defined by the
// parameters and drives registered sync, display enable, pixel coordinates
// and frame/line start strobes. Every output describes the position held in
// the counters, with no skew between outputs.
module vga_sync_controller
    import vga_timing_pkg::*;
#(
    parameter int   h_pixels = VGA640_H_PIXELS,
    parameter int   h_fp     = VGA640_H_FP,
    parameter int   h_pulse  = VGA640_H_PULSE,
    parameter int   h_bp     = VGA640_H_BP,
    parameter logic h_pol    = VGA640_H_POL,
    parameter int   v_pixels = VGA640_V_PIXELS,
    parameter int   v_fp     = VGA640_V_FP,
    parameter int   v_pulse  = VGA640_V_PULSE,
    parameter int   v_bp     = VGA640_V_BP,
    parameter logic v_pol    = VGA640_V_POL
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    vga_sync_controller_if.master vga
);

    localparam int H_PERIOD = axis_period(h_pixels, h_fp, h_pulse, h_bp);
    localparam int V_PERIOD = axis_period(v_pixels, v_fp, v_pulse, v_bp);

    // Both axes must fit the 11-bit counters.
    if (H_PERIOD > MAX_PERIOD) begin : g_h_period_check
        $error("vga_sync_controller: horizontal period exceeds 2048");
    end
    if (V_PERIOD > MAX_PERIOD) begin : g_v_period_check
        $error("vga_sync_controller: vertical period exceeds 2048");
    end

    logic   h_wrap_s;
    logic   h_vis_s;
    logic   h_sync_s;
    coord_t column_s;
    logic   v_wrap_s;
    logic   v_vis_s;
    logic   v_sync_s;
    coord_t row_s;

    logic   h_sync_d,      h_sync_q;
    logic   v_sync_d,      v_sync_q;
    logic   disp_ena_d,    disp_ena_q;
    coord_t column_d,      column_q;
    coord_t row_d,         row_q;
    logic   frame_start_d, frame_start_q;
    logic   line_start_d,  line_start_q;

    // Horizontal axis advances every pixel clock.
    vga_axis_counter #(
        .VISIBLE (h_pixels),
        .FP      (h_fp),
        .PULSE   (h_pulse),
        .BP      (h_bp),
        .POL     (h_pol)
    ) u_h_axis (
        .clk_i          (pixel_clk),
        .reset_i        (reset),
        .advance_i      (1'b1),
        .wrap_o         (h_wrap_s),
        .next_visible_o (h_vis_s),
        .next_sync_o    (h_sync_s),
        .next_coord_o   (column_s)
    );

    // Vertical axis advances once per line, on the horizontal wrap, so
    // v_sync and row only ever change on that edge.
    vga_axis_counter #(
        .VISIBLE (v_pixels),
        .FP      (v_fp),
        .PULSE   (v_pulse),
        .BP      (v_bp),
        .POL     (v_pol)
    ) u_v_axis (
        .clk_i          (pixel_clk),
        .reset_i        (reset),
        .advance_i      (h_wrap_s),
        .wrap_o         (v_wrap_s),
        .next_visible_o (v_vis_s),
        .next_sync_o    (v_sync_s),
        .next_coord_o   (row_s)
    );

    // Output decode of the upcoming position. The vertical wrap can only
    // happen together with a horizontal wrap, so it marks the move to (0,0);
    // a horizontal wrap into a visible line marks column 0 of that line.
    always_comb begin
        h_sync_d      = h_sync_s;
        v_sync_d      = v_sync_s;
        disp_ena_d    = h_vis_s & v_vis_s;
        column_d      = column_s;
        row_d         = row_s;
        frame_start_d = v_wrap_s;
        line_start_d  = h_wrap_s & v_vis_s;
    end

    // Output registers; reset drives every output to its inactive level.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_sync_q      <= ~h_pol;
            v_sync_q      <= ~v_pol;
            disp_ena_q    <= 1'b0;
            column_q      <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            disp_ena_q    <= disp_ena_d;
            column_q      <= column_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.disp_ena    = disp_ena_q;
    assign vga.column      = column_q;
    assign vga.row         = row_q;
    assign vga.frame_start = frame_start_q;
    assign vga.line_start  = line_start_q;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller: a default 640x480 instance for
// horizontal timing and a tiny 14x7 positive-polarity instance for vertical
// timing, frame wrap, polarity and mid-frame reset.
module tb_vga_sync_controller;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_sync_controller_if if_a ();
    vga_sync_controller_if if_b ();

    vga_sync_controller u_dut_a (
        .pixel_clk (clk),
        .reset     (rst_a),
        .vga       (if_a)
    );

    vga_sync_controller #(
        .h_pixels (8), .h_fp (2), .h_pulse (2), .h_bp (2), .h_pol (1'b1),
        .v_pixels (4), .v_fp (1), .v_pulse (1), .v_bp (1), .v_pol (1'b1)
    ) u_dut_b (
        .pixel_clk (clk),
        .reset     (rst_b),
        .vga       (if_b)
    );

    typedef struct {
        int         cyc;
        logic [4:0] flags;   // {disp_ena, h_sync, v_sync, frame_start, line_start}
        logic [10:0] col;
        logic [10:0] row;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input int cyc, input logic de, input logic hs,
                                input logic vs, input logic fs, input logic ls,
                                input int col, input int row);
        vec_t v;
        v.cyc   = cyc;
        v.flags = {de, hs, vs, fs, ls};
        v.col   = 11'(col);
        v.row   = 11'(row);
        return v;
    endfunction

    function automatic logic [26:0] obs_a();
        return {if_a.disp_ena, if_a.h_sync, if_a.v_sync, if_a.frame_start,
                if_a.line_start, if_a.column, if_a.row};
    endfunction

    function automatic logic [26:0] obs_b();
        return {if_b.disp_ena, if_b.h_sync, if_b.v_sync, if_b.frame_start,
                if_b.line_start, if_b.column, if_b.row};
    endfunction

    task automatic check_vec(input string name, input logic [26:0] got,
                             input vec_t exp);
        logic [26:0] e;
        e = {exp.flags, exp.col, exp.row};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got de/hs/vs/fs/ls=%b col=%0d row=%0d, expected de/hs/vs/fs/ls=%b col=%0d row=%0d",
                     name, got[26:22], got[21:11], got[10:0],
                     e[26:22], e[21:11], e[10:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int   cur;
        int   n;
        int   ls_cnt, hs_low, de_hi, hs_first;
        int   vs_hi, hs_hi;
        vec_t v;

        // ---- default mode expectations, cycles counted from frame_start ----
        //            cyc   de hs vs fs ls  col row
        tab_a.push_back(mk(   0, 1, 1, 1, 1, 1,   0, 0));
        tab_a.push_back(mk(   1, 1, 1, 1, 0, 0,   1, 0));
        tab_a.push_back(mk( 639, 1, 1, 1, 0, 0, 639, 0));
        tab_a.push_back(mk( 640, 0, 1, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 655, 0, 1, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 656, 0, 0, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 751, 0, 0, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 752, 0, 1, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 799, 0, 1, 1, 0, 0,   0, 0));
        tab_a.push_back(mk( 800, 1, 1, 1, 0, 1,   0, 1));
        tab_a.push_back(mk( 801, 1, 1, 1, 0, 0,   1, 1));
        tab_a.push_back(mk(1600, 1, 1, 1, 0, 1,   0, 2));
        tab_a.push_back(mk(2239, 1, 1, 1, 0, 0, 639, 2));

        // ---- small mode: h 8/2/2/2 (14), v 4/1/1/1 (7), active-high sync ----
        //            cyc  de hs vs fs ls col row     (h,v)
        tab_b.push_back(mk(  0, 1, 0, 0, 1, 1, 0, 0)); // (0,0)
        tab_b.push_back(mk(  7, 1, 0, 0, 0, 0, 7, 0)); // (7,0)
        tab_b.push_back(mk(  8, 0, 0, 0, 0, 0, 0, 0)); // (8,0)
        tab_b.push_back(mk(  9, 0, 0, 0, 0, 0, 0, 0)); // (9,0)
        tab_b.push_back(mk( 10, 0, 1, 0, 0, 0, 0, 0)); // (10,0)
        tab_b.push_back(mk( 11, 0, 1, 0, 0, 0, 0, 0)); // (11,0)
        tab_b.push_back(mk( 12, 0, 0, 0, 0, 0, 0, 0)); // (12,0)
        tab_b.push_back(mk( 13, 0, 0, 0, 0, 0, 0, 0)); // (13,0)
        tab_b.push_back(mk( 14, 1, 0, 0, 0, 1, 0, 1)); // (0,1)
        tab_b.push_back(mk( 52, 0, 1, 0, 0, 0, 0, 3)); // (10,3)
        tab_b.push_back(mk( 55, 0, 0, 0, 0, 0, 0, 3)); // (13,3)
        tab_b.push_back(mk( 56, 0, 0, 0, 0, 0, 0, 0)); // (0,4)
        tab_b.push_back(mk( 66, 0, 1, 0, 0, 0, 0, 0)); // (10,4)
        tab_b.push_back(mk( 70, 0, 0, 1, 0, 0, 0, 0)); // (0,5)
        tab_b.push_back(mk( 73, 0, 0, 1, 0, 0, 3, 0)); // (3,5)
        tab_b.push_back(mk( 80, 0, 1, 1, 0, 0, 0, 0)); // (10,5)
        tab_b.push_back(mk( 83, 0, 0, 1, 0, 0, 0, 0)); // (13,5)
        tab_b.push_back(mk( 84, 0, 0, 0, 0, 0, 0, 0)); // (0,6)
        tab_b.push_back(mk( 97, 0, 0, 0, 0, 0, 0, 0)); // (13,6)
        tab_b.push_back(mk( 98, 1, 0, 0, 1, 1, 0, 0)); // (0,0)
        tab_b.push_back(mk( 99, 1, 0, 0, 0, 0, 1, 0)); // (1,0)
        tab_b.push_back(mk(196, 1, 0, 0, 1, 1, 0, 0)); // (0,0)

        rst_a = 1'b1;
        rst_b = 1'b1;

        // ---- default mode: 3 reset cycles, then the table ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec($sformatf("a_reset%0d", i), obs_a(),
                      mk(0, 0, 1, 1, 0, 0, 0, 0));
        end
        rst_a = 1'b0;
        cur = -1;
        foreach (tab_a[k]) begin
            v = tab_a[k];
            while (cur < v.cyc) begin
                @(negedge clk);
                cur++;
            end
            check_vec($sformatf("a_cyc%0d", v.cyc), obs_a(), v);
        end

        // ---- default mode: pulse counts over the first two lines ----
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ls_cnt = 0; hs_low = 0; de_hi = 0; hs_first = -1;
        for (int c = 0; c <= 1600; c++) begin
            @(negedge clk);
            if (if_a.line_start) ls_cnt++;
            if (c < 800) begin
                if (!if_a.h_sync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = c;
                end
                if (if_a.disp_ena) de_hi++;
            end
        end
        check_int("a_line_start_count", ls_cnt, 3);
        check_int("a_hsync_low_cycles", hs_low, 96);
        check_int("a_hsync_first_low", hs_first, 656);
        check_int("a_disp_ena_cycles", de_hi, 640);

        // ---- small mode: long-held reset, then the table ----
        check_vec("b_reset_held", obs_b(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_b = 1'b0;
        cur = -1;
        foreach (tab_b[k]) begin
            v = tab_b[k];
            while (cur < v.cyc) begin
                @(negedge clk);
                cur++;
            end
            check_vec($sformatf("b_cyc%0d", v.cyc), obs_b(), v);
        end

        // ---- small mode: frame_start period (bounded wait) ----
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_b.frame_start && n < 300);
        check_int("b_frame_period", n, 98);

        // ---- small mode: sync high cycles over one full frame ----
        vs_hi = 0; hs_hi = 0;
        for (int c = 0; c < 98; c++) begin
            if (if_b.v_sync) vs_hi++;
            if (if_b.h_sync) hs_hi++;
            @(negedge clk);
        end
        check_int("b_vsync_high_cycles", vs_hi, 14);
        check_int("b_hsync_high_cycles", hs_hi, 14);

        // ---- small mode: one-cycle reset at (5,3) ----
        repeat (47) @(negedge clk);
        check_vec("b_pre_reset_5_3", obs_b(), mk(0, 1, 0, 0, 0, 0, 5, 3));
        rst_b = 1'b1;
        @(negedge clk);
        check_vec("b_mid_reset", obs_b(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_b = 1'b0;
        @(negedge clk);
        check_vec("b_restart_0_0", obs_b(), mk(0, 1, 0, 0, 1, 1, 0, 0));
        @(negedge clk);
        check_vec("b_restart_1_0", obs_b(), mk(0, 1, 0, 0, 0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
